// File: rtl/wb16_slave.sv
// wb16_slave: 16-bit Wishbone-style memory slave with a 4-entry in-order
// request queue and a fixed per-request service latency.
//
// Ports:
//   clk_i      sole clock, rising edge
//   reset_i    synchronous, active-high reset (memory contents are kept)
//   wbsadr_i   byte address; word index = wbsadr_i[AW:1]
//   wbsdat_i   write data
//   wbswe_i    1 = write, 0 = read
//   wbsstb_i   request strobe, one request per cycle it is high
//   wbscyc_i   bus cycle active; sampled low flushes all queued requests
//   wbsack_o   completion pulse, one per request, in issue order
//   wbsdat_o   read data while wbsack_o is high, otherwise 0
//   busy_o     high while any request is queued
//   ovf_o      sticky flag: a request was dropped on a full queue
module wb16_slave #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] wbsadr_i,
  input  logic [15:0] wbsdat_i,
  input  logic        wbswe_i,
  input  logic        wbsstb_i,
  input  logic        wbscyc_i,
  output logic        wbsack_o,
  output logic [15:0] wbsdat_o,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;   // pointer width, wraps modulo DEPTH
  localparam int unsigned NW    = 3;   // count width, holds 0..DEPTH
  localparam int unsigned CW    = 4;   // wait counter width, LATENCY <= 15
  localparam int unsigned DW    = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // Request queue storage
  logic          f_we  [DEPTH];
  logic [AW-1:0] f_adr [DEPTH];
  logic [DW-1:0] f_dat [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [NW-1:0] count_q, count_nxt;

  logic [DW-1:0] mem [2**AW];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdat_q;
  logic          ovf_q;

  logic          push, pop, push_ok, ovf_set;
  logic [AW-1:0] push_adr;
  logic          head_we;
  logic [AW-1:0] head_adr;
  logic [DW-1:0] head_dat;
  logic          load_rd, rd_we;
  logic [AW-1:0] rd_adr;

  logic unused_adr_bits;
  assign unused_adr_bits = ^{wbsadr_i[63:AW+1], wbsadr_i[0]};

  // Queue control; a pop only happens on a visible ack
  assign push     = wbscyc_i & wbsstb_i;
  assign pop      = (state_q == S_ACK) & wbscyc_i;
  assign push_ok  = push & ((count_q != NW'(DEPTH)) | pop);
  assign ovf_set  = push & ~push_ok;
  assign push_adr = wbsadr_i[AW:1];
  assign head_we  = f_we[rd_ptr_q];
  assign head_adr = f_adr[rd_ptr_q];
  assign head_dat = f_dat[rd_ptr_q];
  assign count_nxt = NW'(count_q + NW'(push_ok) - NW'(pop));

  // Service FSM next state; the read register is loaded on entry to ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_rd = 1'b0;
    rd_we   = head_we;
    rd_adr  = head_adr;
    if (!wbscyc_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (push) begin
            if (LATENCY == 1) begin
              // The request being pushed becomes the head this edge
              state_d = S_ACK;
              load_rd = 1'b1;
              rd_we   = wbswe_i;
              rd_adr  = push_adr;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CW'(LATENCY - 2);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_ACK;
            load_rd = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_ACK: begin
          // Next head starts counting in the cycle after this ack
          if (count_nxt != '0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state; reset wins over push, pop and flush
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdat_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_q | ovf_set;
      if (load_rd) rdat_q <= rd_we ? '0 : mem[rd_adr];
      if (!wbscyc_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_nxt;
      end
    end
  end

  // Queue payload and memory; memory survives reset
  always_ff @(posedge clk_i) begin
    if (push_ok && !reset_i) begin
      f_we[wr_ptr_q]  <= wbswe_i;
      f_adr[wr_ptr_q] <= push_adr;
      f_dat[wr_ptr_q] <= wbsdat_i;
    end
    if (pop && head_we && !reset_i) mem[head_adr] <= head_dat;
  end

  assign wbsack_o = (state_q == S_ACK) & wbscyc_i;
  assign wbsdat_o = wbsack_o ? rdat_q : '0;
  assign busy_o   = (count_q != '0);
  assign ovf_o    = ovf_q;

endmodule

// File: doc/wb16_slave.md
WB16_SLAVE -- requirements
Module: wb16_slave

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from strobe to ack for a request reaching the queue head on an idle queue; legal range 1..15.
REQ-002 SHALL have parameter AW, default 10, word-address bits; the internal memory holds 2^AW 16-bit words.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port wbsadr_i  in  64  byte address; word index = wbsadr_i[AW:1], bit 0 and bits above AW ignored.
REQ-006 SHALL have port wbsdat_i  in  16  write data.
REQ-007 SHALL have port wbswe_i  in  1  1 = write, 0 = read.
REQ-008 SHALL have port wbsstb_i  in  1  request strobe, one request per cycle it is high.
REQ-009 SHALL have port wbscyc_i  in  1  bus cycle active.
REQ-010 SHALL have port wbsack_o  out  1  request completion, one pulse per request, in issue order.
REQ-011 SHALL have port wbsdat_o  out  16  read data, valid only while wbsack_o is high.
REQ-012 SHALL have port busy_o  out  1  high while any request is queued.
REQ-013 SHALL have port ovf_o  out  1  sticky overflow flag.

Function
REQ-014 SHALL have no stall output; every cycle with wbscyc_i & wbsstb_i high pushes {we, word index, wdat} into a 4-entry in-order FIFO.
REQ-015 SHALL have a service FSM with states IDLE (FIFO empty), WAIT (counting toward the head request's ack), and ACK (ack cycle for the head request).
REQ-016 SHALL, with the FIFO empty and a strobe in cycle 0, assert wbsack_o in cycle LATENCY.
REQ-017 SHALL start the next head request's count in the cycle after an ACK cycle, so back-to-back requests are acked every LATENCY+1 cycles; with LATENCY=1 that is every second cycle.
REQ-018 SHALL perform a write at the clock edge that ends its ACK cycle, drive wbsdat_o = 0 for a write ack, and pop the head entry at that same edge.
REQ-019 SHALL, for a read ack, drive wbsdat_o from a register loaded at the edge entering ACK, with memory contents including every earlier-acked write.
REQ-020 SHALL drive wbsdat_o = 0 whenever wbsack_o is low.
REQ-021 SHALL gate wbsack_o combinationally with wbscyc_i, so an ack is never visible while wbscyc_i is low.
REQ-022 SHALL, whenever wbscyc_i is sampled low, flush the FIFO, return the FSM to IDLE, and discard unacked requests, including writes, while keeping already-performed writes.
REQ-023 SHALL accept a push into a full FIFO without overflow when a pop occurs at the same edge.
REQ-024 SHALL, on a push into a full FIFO with no pop, drop the new request, set ovf_o, and leave existing entries intact.
REQ-025 SHALL clear ovf_o only by reset.
REQ-026 SHALL drive busy_o high exactly when the FIFO count is non-zero, evaluated from registered state.
REQ-027 SHALL use a FIFO count that wraps cleanly over pointers modulo 4 and a count of 0..4.

Reset
REQ-028 SHALL, with reset_i high at an edge, clear the FIFO, FSM (to IDLE), wait counter, wbsack_o, wbsdat_o, busy_o and ovf_o to 0.
REQ-029 SHALL leave memory contents unchanged on reset.
REQ-030 SHALL ignore a strobe in the reset cycle and abort any in-flight request without performing it.
REQ-031 SHALL let reset take priority over the push, pop and flush that would otherwise occur at the same edge.

Verification
REQ-032 SHALL cover: LATENCY=2, write 0xBEEF to adr 0x10 in cycle 0 -> ack in cycle 2; then read adr 0x10 or 0x11 -> ack with wbsdat_o = 0xBEEF.
REQ-033 SHALL cover: LATENCY=1, four strobes in consecutive cycles -> four acks in cycles 1, 3, 5 and 7, in order, with ovf_o = 0.
REQ-034 SHALL cover: LATENCY=3, six consecutive strobes -> ovf_o = 1 and only the first four requests (plus any accepted on a simultaneous pop) acked.
REQ-035 SHALL cover: write 0x1234 queued, wbscyc_i dropped before its ack -> no ack, busy_o = 0 next cycle, and a later read of the address returns its old value.
REQ-036 SHALL cover: reset_i asserted while in WAIT -> all outputs 0 next cycle, and a subsequent read returns memory contents written before the reset.
REQ-037 SHALL cover: write then read to the same address issued back-to-back -> the read ack returns the newly written data.
